fac8_0_burst_rx: RTL

FAC8_0_BURST_RX -- requirements
Module: fac8_0_burst_rx

---
 rtl/fac8_0_burst_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fac8_0_burst_rx.sv
// Burst receiver: captures an 8-beat complex burst, then replays it in
// bit-reversed index order (0,4,2,6,1,5,3,7) with beat index and done pulse.
module fac8_0_burst_rx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] din_re,
  input  logic [DATA_WIDTH-1:0] din_im,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_re,
  output logic [DATA_WIDTH-1:0] dout_im,
  output logic [2:0]            dout_idx,
  output logic                  done,
  output logic                  busy,
  output logic                  err_short,
  output logic                  err_ovf
);

  localparam int unsigned WordW   = 2 * DATA_WIDTH;
  localparam logic [2:0]  LastIdx = 3'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  state_e                state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [2:0]            rcnt_q, rcnt_d;
  logic                  armed_q, armed_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [DATA_WIDTH-1:0] dout_re_q, dout_re_d;
  logic [DATA_WIDTH-1:0] dout_im_q, dout_im_d;
  logic [2:0]            dout_idx_q, dout_idx_d;
  logic                  done_q, done_d;
  logic                  err_short_q, err_short_d;
  logic                  err_ovf_q, err_ovf_d;

  // Capture buffer, packed {re, im}; deliberately not reset.
  logic [WordW-1:0]      mem_q [BURST_LEN];
  logic                  mem_we;
  logic [2:0]            mem_waddr;
  logic [WordW-1:0]      mem_wdata;
  logic [WordW-1:0]      rd_word;

  assign mem_wdata = {din_re, din_im};
  assign rd_word   = mem_q[bitrev3(rcnt_q)];

  // Next-state, buffer write control and registered output values.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    armed_d      = armed_q;
    mem_we       = 1'b0;
    mem_waddr    = wcnt_q;
    dout_valid_d = 1'b0;
    dout_re_d    = dout_re_q;
    dout_im_d    = dout_im_q;
    dout_idx_d   = dout_idx_q;
    done_d       = 1'b0;
    err_short_d  = 1'b0;
    err_ovf_d    = 1'b0;
    case (state_q)
      StIdle: begin
        // Arming needs a low strobe so a still-held valid_in cannot retrigger.
        if (!valid_in) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          mem_we    = 1'b1;
          mem_waddr = 3'd0;
          wcnt_d    = 3'd1;
          armed_d   = 1'b0;
          state_d   = StCapture;
        end
      end
      StCapture: begin
        if (valid_in) begin
          mem_we = 1'b1;
          wcnt_d = wcnt_q + 3'd1;
          if (wcnt_q == LastIdx) begin
            rcnt_d  = 3'd0;
            state_d = StDrain;
          end
        end else begin
          err_short_d = 1'b1;
          wcnt_d      = 3'd0;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        dout_valid_d = 1'b1;
        dout_re_d    = rd_word[WordW-1:DATA_WIDTH];
        dout_im_d    = rd_word[DATA_WIDTH-1:0];
        dout_idx_d   = rcnt_q;
        rcnt_d       = rcnt_q + 3'd1;
        err_ovf_d    = valid_in;
        if (rcnt_q == LastIdx) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wcnt_q       <= 3'd0;
      rcnt_q       <= 3'd0;
      armed_q      <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
      dout_idx_q   <= 3'd0;
      done_q       <= 1'b0;
      err_short_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      armed_q      <= armed_d;
      dout_valid_q <= dout_valid_d;
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
      dout_idx_q   <= dout_idx_d;
      done_q       <= done_d;
      err_short_q  <= err_short_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;
  assign dout_idx   = dout_idx_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);
  assign err_short  = err_short_q;
  assign err_ovf    = err_ovf_q;

endmodule
